// File: rtl/if0_pc_gen_bpu_pkg.sv
// if0_pc_gen_bpu_pkg: shared widths, reset PC, BTB geometry and 2-bit counter encodings
package if0_pc_gen_bpu_pkg;
  localparam int WORD = 32;
  localparam logic [WORD-1:0] RESET_PC = 32'h1c000000;
  localparam int BTB_ENTRIES = 16;
  localparam int IDX = $clog2(BTB_ENTRIES);
  localparam int TAG_W = WORD - IDX - 2;
  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} ctr_t;
endpackage

// File: rtl/if0_pc_gen_bpu_btb_2bit.sv
// btb_2bit: direct-mapped BTB with 2-bit counters, zero-latency lookup and EX-side training
module btb_2bit
  import if0_pc_gen_bpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [WORD-1:0] pc,
  output logic            taken,
  output logic [WORD-1:0] target,
  input  logic            upd_valid,
  input  logic [WORD-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [WORD-1:0] upd_target
);
  logic [BTB_ENTRIES-1:0] valid;
  logic [TAG_W-1:0] tag [BTB_ENTRIES];
  logic [WORD-1:0] tgt [BTB_ENTRIES];
  logic [1:0] ctr [BTB_ENTRIES];
  logic [IDX-1:0] ridx, widx;
  logic [TAG_W-1:0] wtag;
  logic whit, unused_bits;
  assign ridx = pc[IDX+1:2];
  assign widx = upd_pc[IDX+1:2];
  assign wtag = upd_pc[WORD-1:IDX+2];
  assign whit = valid[widx] && tag[widx] == wtag;
  assign taken = valid[ridx] && tag[ridx] == pc[WORD-1:IDX+2] && ctr[ridx][1];
  assign target = tgt[ridx];
  assign unused_bits = ^{pc[1:0], upd_pc[1:0], upd_target[1:0]};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        tag[i] <= '0;
        tgt[i] <= '0;
        ctr[i] <= SNT;
      end
    end else if (upd_valid) begin
      if (whit) begin
        ctr[widx] <= upd_taken ? (ctr[widx] == ST ? ST : ctr[widx] + 2'd1)
                               : (ctr[widx] == SNT ? SNT : ctr[widx] - 2'd1);
        if (upd_taken) tgt[widx] <= {upd_target[WORD-1:2], 2'b00};
      end else if (upd_taken) begin
        valid[widx] <= 1'b1;
        tag[widx] <= wtag;
        tgt[widx] <= {upd_target[WORD-1:2], 2'b00};
        ctr[widx] <= WT;
      end
    end
  end
endmodule

// File: rtl/if0_pc_gen_bpu.sv
// if0_pc_gen_bpu: IF0 fetch PC register with redirect/stall priority and BTB-driven next-PC prediction
module if0_pc_gen_bpu
  import if0_pc_gen_bpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            ex_branch_i,
  input  logic [WORD-1:0] ex_pc_i,
  input  logic            upd_valid_i,
  input  logic [WORD-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  input  logic [WORD-1:0] upd_target_i,
  output logic [WORD-1:0] pc_o,
  output logic            pre_branch_o,
  output logic [WORD-1:0] pre_pc_o
);
  logic [WORD-1:0] btb_target;
  logic unused_bits;
  assign unused_bits = ^ex_pc_i[1:0];
  btb_2bit u_btb (
    .clk(clk),
    .rst(rst),
    .pc(pc_o),
    .taken(pre_branch_o),
    .target(btb_target),
    .upd_valid(upd_valid_i),
    .upd_pc(upd_pc_i),
    .upd_taken(upd_taken_i),
    .upd_target(upd_target_i)
  );
  always_comb pre_pc_o = pre_branch_o ? btb_target : pc_o + WORD'(4);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_o <= RESET_PC;
    else if (ex_branch_i) pc_o <= {ex_pc_i[WORD-1:2], 2'b00};
    else if (!stall_i) pc_o <= pre_pc_o;
  end
endmodule

// File: tb/tb_if0_pc_gen_bpu.sv
// tb_if0_pc_gen_bpu: table-driven directed check of fetch PC sequencing, BTB training and reset
module tb_if0_pc_gen_bpu;
  logic clk = 0, rst = 1, stall_i = 0, ex_branch_i = 0, upd_valid_i = 0, upd_taken_i = 0;
  logic [31:0] ex_pc_i = 0, upd_pc_i = 0, upd_target_i = 0;
  logic [31:0] pc_o, pre_pc_o;
  logic pre_branch_o;
  int checks = 0, failures = 0;

  typedef struct packed {
    logic st, exb;
    logic [31:0] expc;
    logic uv;
    logic [31:0] upc;
    logic ut;
    logic [31:0] utg;
    logic [31:0] epc;
    logic epb;
    logic [31:0] eppc;
  } vec_t;
  vec_t vq[$];

  if0_pc_gen_bpu dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .ex_branch_i(ex_branch_i), .ex_pc_i(ex_pc_i),
    .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i),
    .upd_target_i(upd_target_i), .pc_o(pc_o), .pre_branch_o(pre_branch_o), .pre_pc_o(pre_pc_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] epc, input logic epb, input logic [31:0] eppc);
    chk({tag, " pc_o"}, pc_o, epc);
    chk({tag, " pre_branch_o"}, {31'd0, pre_branch_o}, {31'd0, epb});
    chk({tag, " pre_pc_o"}, pre_pc_o, eppc);
  endtask

  task automatic add(input logic st, input logic exb, input logic [31:0] expc, input logic uv,
                     input logic [31:0] upc, input logic ut, input logic [31:0] utg,
                     input logic [31:0] epc, input logic epb, input logic [31:0] eppc);
    vec_t v;
    v.st = st; v.exb = exb; v.expc = expc; v.uv = uv; v.upc = upc; v.ut = ut; v.utg = utg;
    v.epc = epc; v.epb = epb; v.eppc = eppc;
    vq.push_back(v);
  endtask

  localparam logic [31:0] B = 32'h1c000000;

  initial begin
    //   st exb expc          uv upc       ut utg         | epc          epb eppc
    add(0, 0, 0,            0, 0,        0, 0,           B,           0, B+4);
    add(0, 0, 0,            0, 0,        0, 0,           B+4,         0, B+8);
    add(1, 0, 0,            0, 0,        0, 0,           B+8,         0, B+12);
    add(1, 0, 0,            0, 0,        0, 0,           B+8,         0, B+12);
    add(0, 0, 0,            0, 0,        0, 0,           B+8,         0, B+12);
    add(0, 0, 0,            1, B+'h10,   1, B+'h100,     B+12,        0, B+'h10);
    add(0, 0, 0,            0, 0,        0, 0,           B+'h10,      1, B+'h100);
    add(0, 1, B+'h10,       1, B+'h10,   0, 0,           B+'h100,     0, B+'h104);
    add(1, 0, 0,            1, B+'h10,   0, 0,           B+'h10,      0, B+'h14);
    add(1, 0, 0,            1, B+'h10,   0, 0,           B+'h10,      0, B+'h14);
    add(1, 0, 0,            1, B+'h10,   1, B+'h100,     B+'h10,      0, B+'h14);
    add(1, 0, 0,            1, B+'h10,   1, B+'h100,     B+'h10,      0, B+'h14);
    add(1, 0, 0,            1, B+'h10,   1, B+'h100,     B+'h10,      1, B+'h100);
    add(1, 0, 0,            1, B+'h10,   1, B+'h100,     B+'h10,      1, B+'h100);
    add(1, 0, 0,            1, B+'h10,   0, 0,           B+'h10,      1, B+'h100);
    add(1, 0, 0,            1, B+'h10,   0, 0,           B+'h10,      1, B+'h100);
    add(1, 0, 0,            1, B+'h10,   1, B+'h100,     B+'h10,      0, B+'h14);
    add(1, 1, B+'h203,      1, B+'h50,   1, B+'h300,     B+'h10,      1, B+'h100);
    add(1, 1, B+'h10,       0, 0,        0, 0,           B+'h200,     0, B+'h204);
    add(0, 1, B+'h50,       0, 0,        0, 0,           B+'h10,      0, B+'h14);
    add(0, 1, 32'hfffffffc, 0, 0,        0, 0,           B+'h50,      1, B+'h300);
    add(0, 1, B+'h20,       1, B+'h20,   0, B+'h400,     32'hfffffffc, 0, 32'h0);
    add(0, 0, 0,            0, 0,        0, 0,           B+'h20,      0, B+'h24);

    repeat (2) @(posedge clk);
    #1 chk_out("reset", B, 0, B+4);
    @(negedge clk) rst = 0;
    foreach (vq[i]) begin
      stall_i = vq[i].st; ex_branch_i = vq[i].exb; ex_pc_i = vq[i].expc;
      upd_valid_i = vq[i].uv; upd_pc_i = vq[i].upc; upd_taken_i = vq[i].ut; upd_target_i = vq[i].utg;
      #1 chk_out($sformatf("vec%0d", i), vq[i].epc, vq[i].epb, vq[i].eppc);
      @(posedge clk); #1;
    end
    stall_i = 0; upd_valid_i = 0;
    ex_branch_i = 1; ex_pc_i = B+'h50;
    @(posedge clk); #1;
    ex_branch_i = 0;
    chk_out("pre_reset", B+'h50, 1, B+'h300);
    #2 rst = 1;
    #1 chk_out("async_reset", B, 0, B+4);
    upd_valid_i = 1; upd_pc_i = B+'h50; upd_taken_i = 1; upd_target_i = B+'h500;
    @(posedge clk); #1;
    upd_valid_i = 0;
    chk_out("held_reset", B, 0, B+4);
    @(negedge clk) rst = 0;
    ex_branch_i = 1; ex_pc_i = B+'h50;
    @(posedge clk); #1;
    ex_branch_i = 0;
    chk_out("post_reset", B+'h50, 0, B+'h54);
    @(posedge clk); #1;
    chk_out("post_reset_seq", B+'h54, 0, B+'h58);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
